// File: rtl/ps2_device_port.sv
// Device-side PS/2 endpoint: drives the PS/2 clock, sends bytes to the host and
// receives host commands (with acknowledge) over open-drain clock/data lines.
module ps2_device_port #(
   parameter int HALF_PERIOD = 2000,
   parameter int IDLE_CYCLES = 2500
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_error,
   inout  wire        PS2_CLK,
   inout  wire        PS2_DAT
);
   localparam int CW = $clog2(2 * HALF_PERIOD + 1);
   localparam int IW = $clog2(IDLE_CYCLES + 1);
   localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(2 * HALF_PERIOD - 1);
   localparam logic [CW-1:0] RX_SAMP  = CW'(2);
   localparam logic [IW-1:0] IDLE_SAT = IW'(IDLE_CYCLES);

   typedef enum logic [2:0] {S_IDLE, S_TX, S_INHIBIT, S_RX, S_ACK, S_GAP} state_t;

   state_t        state_q, state_d;
   logic          clk_meta_q, clk_s_q, dat_meta_q, dat_s_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          low_q, low_d;
   logic [3:0]    bit_q, bit_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [7:0]    hold_q, hold_d;
   logic          hold_vld_q, hold_vld_d;
   logic [7:0]    sr_q, sr_d;
   logic          par_q, par_d;
   logic          err_q, err_d;
   logic          drv_clk_q, drv_clk_d;
   logic          drv_dat_q, drv_dat_d;
   logic          tx_done_q, tx_done_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_error_q, rx_error_d;
   logic [7:0]    rx_data_q, rx_data_d;

   logic          idle_sat;
   logic          accept;
   logic          hp_end;
   logic [3:0]    nxt_bit;
   logic [15:0]   frame_bits;

   // Lines are only ever pulled low or released.
   assign PS2_CLK = drv_clk_q ? 1'b0 : 1'bz;
   assign PS2_DAT = drv_dat_q ? 1'b0 : 1'bz;

   assign idle_sat   = (idle_q == IDLE_SAT);
   assign tx_ready   = (state_q == S_IDLE) && idle_sat && !hold_vld_q;
   assign accept     = tx_valid && tx_ready;
   assign hp_end     = (cnt_q == HP_LAST);
   assign nxt_bit    = bit_q + 4'd1;
   assign frame_bits = {5'b0, 1'b1, ~^hold_q, hold_q, 1'b0};

   assign tx_done  = tx_done_q;
   assign rx_valid = rx_valid_q;
   assign rx_error = rx_error_q;
   assign rx_data  = rx_data_q;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         clk_meta_q <= 1'b0;
         clk_s_q    <= 1'b0;
         dat_meta_q <= 1'b0;
         dat_s_q    <= 1'b0;
         cnt_q      <= '0;
         low_q      <= 1'b0;
         bit_q      <= '0;
         idle_q     <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         sr_q       <= '0;
         par_q      <= 1'b0;
         err_q      <= 1'b0;
         drv_clk_q  <= 1'b0;
         drv_dat_q  <= 1'b0;
         tx_done_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_error_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         clk_meta_q <= PS2_CLK;
         clk_s_q    <= clk_meta_q;
         dat_meta_q <= PS2_DAT;
         dat_s_q    <= dat_meta_q;
         cnt_q      <= cnt_d;
         low_q      <= low_d;
         bit_q      <= bit_d;
         idle_q     <= idle_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         sr_q       <= sr_d;
         par_q      <= par_d;
         err_q      <= err_d;
         drv_clk_q  <= drv_clk_d;
         drv_dat_q  <= drv_dat_d;
         tx_done_q  <= tx_done_d;
         rx_valid_q <= rx_valid_d;
         rx_error_q <= rx_error_d;
         rx_data_q  <= rx_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      low_d      = low_q;
      bit_d      = bit_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      sr_d       = sr_q;
      par_d      = par_q;
      err_d      = err_q;
      drv_clk_d  = drv_clk_q;
      drv_dat_d  = drv_dat_q;
      tx_done_d  = 1'b0;
      rx_valid_d = 1'b0;
      rx_error_d = rx_error_q;
      rx_data_d  = rx_data_q;

      // Bus must look idle continuously, and our own drive never counts as idle.
      if (drv_clk_q || drv_dat_q || !(clk_s_q && dat_s_q)) idle_d = '0;
      else if (!idle_sat) idle_d = idle_q + IW'(1);
      else idle_d = idle_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               hold_d     = tx_data;
               hold_vld_d = 1'b1;
            end
            if (!clk_s_q) begin
               state_d = S_INHIBIT;
            end else if (accept || (hold_vld_q && idle_sat)) begin
               state_d   = S_TX;
               cnt_d     = '0;
               low_d     = 1'b0;
               bit_d     = '0;
               drv_dat_d = 1'b1;
            end
         end
         S_TX: begin
            cnt_d = cnt_q + CW'(1);
            if (!low_q) begin
               if (hp_end) begin
                  // Host inhibit aborts the frame unless parity or stop is already on the wire.
                  if (!clk_s_q && bit_q < 4'd9) begin
                     state_d   = S_INHIBIT;
                     drv_clk_d = 1'b0;
                     drv_dat_d = 1'b0;
                  end else begin
                     low_d     = 1'b1;
                     cnt_d     = '0;
                     drv_clk_d = 1'b1;
                  end
               end
            end else if (hp_end) begin
               cnt_d     = '0;
               drv_clk_d = 1'b0;
               if (bit_q == 4'd10) begin
                  state_d    = S_GAP;
                  drv_dat_d  = 1'b0;
                  tx_done_d  = 1'b1;
                  hold_d     = '0;
                  hold_vld_d = 1'b0;
               end else begin
                  bit_d     = nxt_bit;
                  low_d     = 1'b0;
                  drv_dat_d = ~frame_bits[nxt_bit];
               end
            end
         end
         S_INHIBIT: begin
            if (clk_s_q) begin
               if (!dat_s_q) begin
                  state_d   = S_RX;
                  cnt_d     = '0;
                  low_d     = 1'b1;
                  bit_d     = '0;
                  drv_clk_d = 1'b1;
                  sr_d      = '0;
                  par_d     = 1'b0;
                  err_d     = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_RX: begin
            cnt_d = cnt_q + CW'(1);
            if (low_q) begin
               if (hp_end) begin
                  low_d     = 1'b0;
                  cnt_d     = '0;
                  drv_clk_d = 1'b0;
               end
            end else begin
               if (cnt_q == RX_SAMP) begin
                  if (bit_q < 4'd8) sr_d = {dat_s_q, sr_q[7:1]};
                  if (bit_q < 4'd9) par_d = par_q ^ dat_s_q;
                  else err_d = !dat_s_q || !par_q;
               end
               if (hp_end) begin
                  cnt_d     = '0;
                  low_d     = 1'b1;
                  drv_clk_d = 1'b1;
                  if (bit_q == 4'd9) begin
                     state_d   = S_ACK;
                     drv_dat_d = 1'b1;
                  end else begin
                     bit_d = nxt_bit;
                  end
               end
            end
         end
         S_ACK: begin
            cnt_d = cnt_q + CW'(1);
            if (low_q) begin
               if (hp_end) begin
                  low_d     = 1'b0;
                  cnt_d     = '0;
                  drv_clk_d = 1'b0;
               end
            end else if (hp_end) begin
               state_d    = S_GAP;
               cnt_d      = '0;
               drv_dat_d  = 1'b0;
               rx_data_d  = sr_q;
               rx_error_d = err_q;
               rx_valid_d = 1'b1;
            end
         end
         S_GAP: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_ps2_device_port.sv
// Self-checking bench for ps2_device_port: a bench-side host plus scoreboards for
// device-to-host frames and host-to-device commands.
module tb_ps2_device_port;
   localparam int HP   = 16;
   localparam int IDLE = 40;
   localparam int TMO  = 4 * IDLE + 80 * HP;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_error;
   wire        PS2_CLK;
   wire        PS2_DAT;

   logic host_clk_low = 1'b0;
   logic host_dat_low = 1'b0;
   logic host_active  = 1'b0;

   pullup (PS2_CLK);
   pullup (PS2_DAT);
   assign PS2_CLK = host_clk_low ? 1'b0 : 1'bz;
   assign PS2_DAT = host_dat_low ? 1'b0 : 1'bz;

   ps2_device_port #(.HALF_PERIOD(HP), .IDLE_CYCLES(IDLE)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_done(tx_done), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_error(rx_error), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int n_checks = 0;
   int n_pass   = 0;
   longint cyc  = 0;
   int acc_cnt  = 0;
   longint acc_cyc = 0;
   int done_cnt = 0;
   int rx_cnt   = 0;
   longint rxv_cyc = 0;
   longint last_fall = 0;
   longint first_fall = 0;
   logic prev_clk = 1'b1;

   logic [10:0] tx_exp[$];
   logic [8:0]  rx_exp[$];
   logic        tx_bits[$];

   task automatic chk(input string name, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
   endtask

   // Reference frame: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
      f[9]  = (($countones(d) % 2) == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   always @(posedge CLOCK_50) begin
      cyc++;
      if (!reset && tx_valid && tx_ready) begin
         tx_exp.push_back(frame_of(tx_data));
         acc_cnt++;
         acc_cyc = cyc;
      end
   end

   always @(negedge CLOCK_50) begin
      logic        cur;
      logic [10:0] got, e;
      logic [8:0]  r;
      cur = PS2_CLK;
      if (prev_clk === 1'b1 && cur === 1'b0 && !host_active) begin
         if (tx_bits.size() > 0) chk("fall_spacing", cyc - last_fall, 2 * HP);
         else first_fall = cyc;
         last_fall = cyc;
         tx_bits.push_back(PS2_DAT);
      end
      prev_clk = cur;
      if (tx_done) begin
         done_cnt++;
         got = '0;
         for (int i = 0; i < tx_bits.size() && i < 11; i++) got[i] = tx_bits[i];
         $display("tx frame %b (%0d falling edges)", got, tx_bits.size());
         chk("tx_exp_pending", tx_exp.size() > 0, 1);
         if (tx_exp.size() > 0) begin
            e = tx_exp.pop_front();
            chk("tx_bit_count", tx_bits.size(), 11);
            chk("tx_frame", got, e);
         end
         tx_bits.delete();
      end
      if (rx_valid) begin
         rx_cnt++;
         rxv_cyc = cyc;
         $display("rx data 0x%02h error %0b", rx_data, rx_error);
         chk("rx_exp_pending", rx_exp.size() > 0, 1);
         if (rx_exp.size() > 0) begin
            r = rx_exp.pop_front();
            chk("rx_data", rx_data, r[7:0]);
            chk("rx_error", rx_error, r[8]);
         end
      end
   end

   task automatic wait_fall(output bit ok);
      logic prev, cur;
      ok = 1'b0;
      prev = PS2_CLK;
      for (int i = 0; i < TMO; i++) begin
         @(negedge CLOCK_50);
         cur = PS2_CLK;
         if (prev && !cur) begin
            ok = 1'b1;
            break;
         end
         prev = cur;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int  a0;
      bit  ok;
      a0 = acc_cnt;
      ok = 1'b0;
      tx_data  = b;
      tx_valid = 1'b1;
      for (int i = 0; i < TMO; i++) begin
         @(negedge CLOCK_50);
         if (acc_cnt != a0) begin
            ok = 1'b1;
            break;
         end
      end
      tx_valid = 1'b0;
      chk("tx_accept", ok, 1);
   endtask

   task automatic wait_done(input int d0, input string name);
      for (int i = 0; i < TMO && done_cnt == d0; i++) @(negedge CLOCK_50);
      chk(name, done_cnt - d0, 1);
   endtask

   task automatic host_send(input logic [7:0] d, input bit par_bad, input bit stop_bad,
                            input bit raise_tx);
      logic [9:0] bits;
      logic       exp_err;
      bit         ok, all_ok;
      int         r0;
      bits[7:0] = d;
      bits[8]   = ((($countones(d) % 2) == 0) ? 1'b1 : 1'b0) ^ par_bad;
      bits[9]   = !stop_bad;
      exp_err   = ((($countones(d) + int'(bits[8])) % 2) != 1) || !bits[9];
      rx_exp.push_back({exp_err, d});
      $display("host cmd 0x%02h parity %0b stop %0b", d, bits[8], bits[9]);
      r0 = rx_cnt;
      all_ok = 1'b1;
      host_active = 1'b1;
      @(negedge CLOCK_50);
      host_clk_low = 1'b1;
      repeat (3 * HP) @(negedge CLOCK_50);
      host_dat_low = 1'b1;
      repeat (4) @(negedge CLOCK_50);
      if (raise_tx) begin
         tx_data  = 8'h5A;
         tx_valid = 1'b1;
      end
      host_clk_low = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wait_fall(ok);
         all_ok &= ok;
         if (!ok) break;
         host_dat_low = !bits[i];
      end
      chk("rx_slot_clocks", all_ok, 1);
      if (all_ok) begin
         wait_fall(ok);
         host_dat_low = 1'b0;
         chk("ack_clock", ok, 1);
         #1;
         chk("ack_data_low", PS2_DAT, 0);
      end
      host_dat_low = 1'b0;
      for (int i = 0; i < TMO && rx_cnt == r0; i++) @(negedge CLOCK_50);
      chk("rx_valid_seen", rx_cnt - r0, 1);
      host_active = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  k, d0, r0, a0;
      bit  ok;
      longint rel;
      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (5) @(negedge CLOCK_50);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_tx_done", tx_done, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_error", rx_error, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_clk_line", PS2_CLK, 1);
      chk("rst_dat_line", PS2_DAT, 1);
      reset = 1'b0;

      k = 0;
      for (int i = 1; i <= TMO; i++) begin
         @(posedge CLOCK_50);
         @(negedge CLOCK_50);
         if (tx_ready) begin
            k = i;
            break;
         end
      end
      chk("ready_latency", k, IDLE + 2);

      d0 = done_cnt;
      send_byte(8'h1C);
      wait_done(d0, "tx_1c_done");
      repeat (4) @(negedge CLOCK_50);
      chk("after_tx_clk_high", PS2_CLK, 1);
      chk("after_tx_dat_high", PS2_DAT, 1);

      host_send(8'hED, 1'b0, 1'b0, 1'b0);
      // F4 with its parity bit inverted so the device must flag an error.
      host_send(8'hF4, 1'b1, 1'b0, 1'b0);

      d0 = done_cnt;
      send_byte(8'hAA);
      for (int i = 0; i < 4; i++) wait_fall(ok);
      chk("aa_four_edges", ok, 1);
      repeat (HP + HP / 2) @(negedge CLOCK_50);
      host_active  = 1'b1;
      host_clk_low = 1'b1;
      repeat (HP / 2 + 4) @(negedge CLOCK_50);
      chk("inhibit_dat_released", PS2_DAT, 1);
      repeat (2 * HP) @(negedge CLOCK_50);
      chk("inhibit_dat_still_released", PS2_DAT, 1);
      chk("inhibit_no_done", done_cnt - d0, 0);
      tx_bits.delete();
      rel = cyc;
      host_clk_low = 1'b0;
      host_active  = 1'b0;
      wait_done(d0, "aa_retx_done");
      chk("retx_after_idle", (first_fall - rel) >= IDLE, 1);

      d0 = done_cnt;
      a0 = acc_cnt;
      host_send(8'hFF, 1'b0, 1'b0, 1'b1);
      chk("no_accept_during_rx", acc_cnt - a0, 0);
      for (int i = 0; i < TMO && acc_cnt == a0; i++) @(negedge CLOCK_50);
      tx_valid = 1'b0;
      chk("5a_accepted", acc_cnt - a0, 1);
      chk("5a_after_gap_idle", ((acc_cyc - rxv_cyc) >= IDLE) && ((acc_cyc - rxv_cyc) >= 2 * HP), 1);
      wait_done(d0, "5a_done");
      repeat (2 * IDLE) @(negedge CLOCK_50);
      chk("5a_single_done", done_cnt - d0, 1);

      for (int n = 0; n < 14; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            d0 = done_cnt;
            send_byte(8'($urandom));
            wait_done(d0, "rand_tx_done");
         end else begin
            host_send(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, 1'b0);
         end
         repeat ($urandom_range(0, 20)) @(negedge CLOCK_50);
      end

      // Abort a frame with reset while the device is pulling both lines low.
      send_byte(8'h00);
      for (int i = 0; i < 7; i++) wait_fall(ok);
      chk("pre_reset_edges", ok, 1);
      repeat (3) @(negedge CLOCK_50);
      chk("pre_reset_clk_low", PS2_CLK, 0);
      chk("pre_reset_dat_low", PS2_DAT, 0);
      #2 reset = 1'b1;
      #1;
      chk("midrst_clk_released", PS2_CLK, 1);
      chk("midrst_dat_released", PS2_DAT, 1);
      chk("midrst_tx_ready", tx_ready, 0);
      chk("midrst_tx_done", tx_done, 0);
      chk("midrst_rx_valid", rx_valid, 0);
      chk("midrst_rx_error", rx_error, 0);
      chk("midrst_rx_data", rx_data, 0);
      tx_exp.delete();
      tx_bits.delete();
      repeat (3) @(negedge CLOCK_50);
      reset = 1'b0;
      d0 = done_cnt;
      r0 = rx_cnt;
      repeat (2 * IDLE + 4 * HP) @(negedge CLOCK_50);
      chk("postrst_no_tx_done", done_cnt - d0, 0);
      chk("postrst_no_rx_valid", rx_cnt - r0, 0);
      chk("postrst_ready", tx_ready, 1);

      chk("tx_queue_drained", tx_exp.size(), 0);
      chk("rx_queue_drained", rx_exp.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
